// File: rtl/mul_operand_sequencer.sv
// Operand FIFO + load/run/hold sequencer in front of the sequential 8x8 multiplier.
// Optional RUN watchdog is enabled with `define MUL_SEQ_TIMEOUT_EN.
module mul_operand_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_reset,
  input  logic        mul_rdy,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_err,
  output logic        busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    fifo_a [DEPTH];
  logic [7:0]    fifo_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, capture, abort, run_first, tmo_hit;

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // The watchdog counter is 5 bits wide, so TIMEOUT has to fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_timeout_out_of_range
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam logic [4:0] TMO = 5'(TIMEOUT);
  logic [4:0] run_cnt;

  assign tmo_hit = (run_cnt == TMO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == LOAD)
        run_cnt <= '0;
      else if (state == RUN && !tmo_hit)
        run_cnt <= run_cnt + 5'd1;
      if (capture)
        out_err <= 1'b0;
      else if (abort)
        out_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

  // Storage has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      // A rdy left over from the previous product may still be high in the first RUN cycle.
      RUN: if (!run_first && mul_rdy) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end else if (tmo_hit) begin
        abort     = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mul_reset <= 1'b1;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      run_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      mul_reset <= (state_nxt == LOAD);
      run_first <= (state == LOAD);
      if (pop) begin
        mul_a <= fifo_a[rd_ptr];
        mul_b <= fifo_b[rd_ptr];
      end
      if (capture) begin
        out_p     <= mul_p;
        out_valid <= 1'b1;
      end else if (abort) begin
        out_p     <= '0;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
